// File: rtl/shift_mix_stage.sv
// shift_mix_stage: AES forward ShiftRows followed by MixColumns as a
// two-stage valid/ready pipeline. Stage 1 registers the ShiftRows result;
// stage 2 registers the MixColumns result, or passes stage 1 data through
// for final-round blocks or when ENABLE_MIX = 0.
// Byte i of a state lives at bits [8i +: 8]; byte index = 4*col + row.
module shift_mix_stage #(
    parameter int ENABLE_MIX = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_state,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state,
    output logic         out_last,
    output logic [15:0]  blocks_done
);

    // GF(2^8) multiply by 2, reduction polynomial 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // out byte (4c+r) takes in byte (4*((c+r) mod 4)+r); row 0 is unchanged
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] r;
        r = '0;
        for (int col = 0; col < 4; col++) begin
            for (int row = 0; row < 4; row++) begin
                r[8*(4*col+row) +: 8] = s[8*(4*((col+row)%4)+row) +: 8];
            end
        end
        return r;
    endfunction

    // Standard MixColumns matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2]
    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int col = 0; col < 4; col++) begin
            a0 = s[8*(4*col+0) +: 8];
            a1 = s[8*(4*col+1) +: 8];
            a2 = s[8*(4*col+2) +: 8];
            a3 = s[8*(4*col+3) +: 8];
            r[8*(4*col+0) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[8*(4*col+1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[8*(4*col+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[8*(4*col+3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    logic         s1_valid;
    logic         s1_last;
    logic [0:127] s1_data;
    logic         s2_valid;
    logic         s2_last;
    logic [0:127] s2_data;
    logic         s2_adv;
    logic         s1_adv;
    logic [0:127] s2_next;

    // Handshake control: stage 2 drains when empty or downstream takes it,
    // stage 1 can refill whenever it is empty or moving on
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = s1_valid && s2_adv;
        in_ready = !s1_valid || s2_adv;
    end

    // Stage 2 data select: final-round blocks skip MixColumns
    always_comb begin
        s2_next = s1_data;
        if (ENABLE_MIX != 0 && !s1_last) begin
            s2_next = mix_columns(s1_data);
        end
    end

    // Stage 1: capture ShiftRows of an accepted block; data only loads on a real accept
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= shift_rows(in_state);
                s1_last <= in_last;
            end
        end
    end

    // Stage 2: output register, held while the downstream stalls
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_data  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_adv) begin
                s2_data <= s2_next;
                s2_last <= s1_last;
            end
        end
    end

    // Completed-output counter, saturating at all ones
    always_ff @(posedge clock) begin
        if (reset) begin
            blocks_done <= 16'h0000;
        end else if (s2_valid && out_ready && blocks_done != 16'hFFFF) begin
            blocks_done <= blocks_done + 16'h0001;
        end
    end

    // Outputs come straight from the stage 2 registers
    always_comb begin
        out_valid = s2_valid;
        out_state = s2_data;
        out_last  = s2_last;
    end

endmodule

// File: doc/shift_mix_stage.md
SHIFT_MIX_STAGE -- requirements
Module: shift_mix_stage

Interface
REQ-001 SHALL have parameter ENABLE_MIX, default 1; 1 = ShiftRows then MixColumns, 0 = ShiftRows only for all blocks.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream block valid.
REQ-005 SHALL have port in_ready  output  1  block accepted when in_valid && in_ready.
REQ-006 SHALL have port in_state  input  [0:127]  AES state.
- Byte i = bits [8i +: 8].
- Byte index = 4*col + row.
REQ-007 SHALL have port in_last  input  1  final-round flag; MixColumns is skipped for this block.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-010 SHALL have port out_state  output  [0:127]  result, same byte ordering as in_state.
REQ-011 SHALL have port out_last  output  1  in_last carried alongside the block.
REQ-012 SHALL have port blocks_done  output  16  count of completed output handshakes.

Function
REQ-013 SHALL implement forward ShiftRows, the inverse of the team's inv_shift_rows: out byte (4c+r) = in byte (4*((c+r) mod 4)+r).
- Row 0 unchanged.
- Example mapping: out byte 1 = in byte 5; out byte 2 = in byte 10; out byte 3 = in byte 15.
REQ-014 SHALL implement MixColumns per column a0..a3 over GF(2^8), xtime reduction polynomial 0x1B:
- b0 = 2a0^3a1^a2^a3
- b1 = a0^2a1^3a2^a3
- b2 = a0^a1^2a2^3a3
- b3 = 3a0^a1^a2^2a3
REQ-015 SHALL be a two-stage registered pipeline.
- Stage 1 (S1) registers the ShiftRows result, in_last and a valid bit.
- Stage 2 (S2) registers the MixColumns result, or the S1 data unchanged when the S1 last flag = 1 or ENABLE_MIX = 0, plus last and valid bits.
REQ-016 SHALL drive out_state, out_last and out_valid directly from the S2 registers; no combinational input-to-output data path.
REQ-017 SHALL advance S2 when !S2.valid || out_ready.
REQ-018 SHALL advance S1 into S2 when S1.valid && S2 advances.
REQ-019 SHALL compute in_ready = !S1.valid || (S2 advances); full throughput of one block per cycle when out_ready = 1.
REQ-020 SHALL give a latency of 2 cycles from input handshake to out_valid, with no stalls.
REQ-021 SHALL hold out_state, out_last and out_valid stable while out_valid && !out_ready; no block is dropped or duplicated.
REQ-022 SHALL clear a stage's valid bit when it empties and nothing refills it; data registers may hold stale values when invalid.
REQ-023 SHALL accept a new input and emit an output in the same cycle; the two handshakes do not interfere.
REQ-024 SHALL increment blocks_done on each output handshake and saturate at 16'hFFFF.
REQ-025 SHALL ignore in_state and in_last when in_valid = 0.

Reset
REQ-026 SHALL, on reset, clear S1.valid, S2.valid, out_valid, out_last and blocks_done to 0, and out_state to 128'h0.
REQ-027 SHALL give reset priority over all handshakes; in-flight blocks are discarded, not emitted.
REQ-028 SHALL drive in_ready = 1 in the first cycle after reset deasserts.

Verification
REQ-029 Single block, ENABLE_MIX = 1, in_last = 0, out_ready = 1: in_state d4bf5d30... is not used; in_state = d42711aee0bf98f1b8b45de51e415230 -> out_state = 046681e5e0cb199a48f8d37a2806264c, out_valid 2 cycles after the accept.
REQ-030 Same input with in_last = 1 -> out_state = d4bf5d30e0b452aeb84111f11e2798e5, out_last = 1.
REQ-031 Back-pressure: 4 consecutive blocks with out_ready = 0 -> in_ready falls after 2 accepts and out_state holds. Raising out_ready -> all 4 emerge in order, one per cycle, and blocks_done = 4.
REQ-032 Column check: a column (bytes 0,5,10,15) = db,13,53,45 with all other bytes 0, ENABLE_MIX = 1 -> out bytes 0..3 = 8e,4d,a1,bc.
REQ-033 Reset mid-stream: reset asserted with both stages valid -> next cycle out_valid = 0, blocks_done = 0, out_state = 0, in_ready = 1, and no stale block emerges afterwards.
REQ-034 Saturation: preload blocks_done = 16'hFFFE via 2 forced handshakes -> count holds at 16'hFFFF on further outputs.
